// File: rtl/skid_pipe_reg.sv
// skid_pipe_reg: elastic pipeline stage with valid/ready on both sides.
// A main register drives out_data directly; a skid register catches the one
// extra word that can arrive in the cycle after downstream stalls, so in_ready
// can stay registered without losing throughput.
// Optional feature macro: SKID_STALL_CNT_EN adds a saturating 16-bit stall_cnt
// output counting cycles with out_valid & !out_ready.
module skid_pipe_reg #(
    parameter int               WIDTH = 32,
    parameter logic [0:WIDTH-1] RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_data
`ifdef SKID_STALL_CNT_EN
    ,
    output logic [0:15]      stall_cnt
`endif
);

    // EMPTY: nothing held; BUSY: main holds a word; FULL: main and skid hold words
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state;
    logic [0:WIDTH-1] main_p0;
    logic [0:WIDTH-1] skid_p0;
    logic             acc;
    logic             take;

    assign acc      = in_valid & in_ready;
    assign take     = out_valid & out_ready;
    assign out_data = main_p0;

    // Handshake state machine; out_valid/in_ready are registered alongside state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_p0   <= RESET;
            skid_p0   <= RESET;
        end else if (flush) begin
            // Flush wins over any simultaneous transfer; the incoming word is dropped
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_p0   <= RESET;
            skid_p0   <= RESET;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        main_p0   <= in_data;
                        state     <= ST_BUSY;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (acc && take) begin
                        main_p0 <= in_data;
                    end else if (acc) begin
                        // Downstream stalled: park the new word behind main
                        skid_p0  <= in_data;
                        state    <= ST_FULL;
                        in_ready <= 1'b0;
                    end else if (take) begin
                        // main keeps the last word so out_data stays stable when idle
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so in_valid cannot cause an acceptance
                    if (take) begin
                        main_p0  <= skid_p0;
                        state    <= ST_BUSY;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef SKID_STALL_CNT_EN
    function automatic logic [0:15] sat_inc(input logic [0:15] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stall counter: counts cycles a valid word waits on downstream, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (flush) begin
            stall_cnt <= 16'd0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Testbench for skid_pipe_reg: directed scenarios plus a randomized run against
// a queue-based occupancy model. Honours SKID_STALL_CNT_EN when defined.
module tb_skid_pipe_reg;

    localparam logic [0:31] RST_VAL = 32'hDEADBEEF;
`ifdef SKID_STALL_CNT_EN
    localparam int NWORDS = 2000;
`else
    localparam int NWORDS = 10000;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [0:31] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [0:31] out_data;
`ifdef SKID_STALL_CNT_EN
    logic [0:15] stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    skid_pipe_reg #(.WIDTH(32), .RESET(RST_VAL)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h0000_0055; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h55) begin
            n_fail++;
            $display("FAIL reset_preload: valid=%b data=%h want valid=1 data=00000055", out_valid, out_data);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_tests++;
        if (out_data !== RST_VAL) begin
            n_fail++; $display("FAIL reset_out_data: got %h want %h", out_data, RST_VAL);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== RST_VAL) begin
            n_fail++; $display("FAIL reset_release: valid=%b data=%h want 0/%h", out_valid, out_data, RST_VAL);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'(i);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_in_ready word %0d: got %b want 1", i, in_ready);
            end
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                n_fail++;
                $display("FAIL stream_out word %0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, 32'(i));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 32'h8) begin
            n_fail++; $display("FAIL stream_drain: valid=%b data=%h want 0/00000008", out_valid, out_data);
        end
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        @(negedge clk);
        in_data = 32'hB;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_ready_before_b: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
            n_fail++; $display("FAIL bp_full: ready=%b valid=%b data=%h want 0/1/0000000a", in_ready, out_valid, out_data);
        end
        @(negedge clk);
        in_data = 32'hC;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b0 || out_data !== 32'hA) begin
            n_fail++; $display("FAIL bp_hold_c: ready=%b data=%h want 0/0000000a", in_ready, out_data);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_out_b: valid=%b data=%h ready=%b want 1/0000000b/1", out_valid, out_data, in_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hC) begin
            n_fail++; $display("FAIL bp_out_c: valid=%b data=%h want 1/0000000c", out_valid, out_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_dup: valid=%b data=%h want valid 0", out_valid, out_data);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        @(negedge clk);
        in_data = 32'hB;
        @(negedge clk);
        in_data = 32'hC; flush = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== RST_VAL) begin
            n_fail++; $display("FAIL flush_full: valid=%b ready=%b data=%h want 0/1/%h", out_valid, in_ready, out_data, RST_VAL);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_full_leak cycle %0d: valid=%b data=%h want valid 0", i, out_valid, out_data);
            end
        end
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
        @(negedge clk);
        in_data = 32'h88; flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== RST_VAL) begin
            n_fail++; $display("FAIL flush_busy: valid=%b data=%h want 0/%h", out_valid, out_data, RST_VAL);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_busy_drop: valid=%b data=%h want valid 0", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        logic [0:31] q[$];
        logic [0:31] last;
        logic [0:31] prev_data;
        logic        prev_stall;
        logic        pending;
        logic        acc;
        logic        take;
        int          sent;
        int          rcvd;
        int          cycles;

        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        q.delete();
        last = RST_VAL; pending = 1'b0; prev_stall = 1'b0; prev_data = '0;
        sent = 0; rcvd = 0; cycles = 0;

        while (rcvd < NWORDS && cycles < NWORDS * 8) begin
            n_tests++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_flags cycle %0d: valid=%b ready=%b want %b/%b",
                         cycles, out_valid, in_ready, q.size() > 0, q.size() < 2);
            end
            n_tests++;
            if (out_data !== ((q.size() > 0) ? q[0] : last)) begin
                n_fail++;
                $display("FAIL rand_data cycle %0d: got %h want %h", cycles, out_data, (q.size() > 0) ? q[0] : last);
            end
            if (prev_stall) begin
                n_tests++;
                if (out_data !== prev_data) begin
                    n_fail++; $display("FAIL rand_stable cycle %0d: got %h want %h", cycles, out_data, prev_data);
                end
            end

            if (!pending) begin
                in_valid = (sent < NWORDS) && ($urandom_range(0, 1) == 1);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            acc  = in_valid && (q.size() < 2);
            take = (q.size() > 0) && out_ready;
            prev_stall = (q.size() > 0) && !out_ready;
            prev_data  = out_data;

            @(posedge clk);
            if (take) begin
                last = q.pop_front();
                rcvd++;
            end
            if (acc) begin
                q.push_back(in_data);
                sent++;
            end
            pending = in_valid && !acc;
            cycles++;
            @(negedge clk);
        end
        n_tests++;
        if (rcvd != NWORDS) begin
            n_fail++; $display("FAIL rand_timeout: received %0d words want %0d", rcvd, NWORDS);
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

`ifdef SKID_STALL_CNT_EN
    task automatic test_stall_cnt();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (stall_cnt !== 16'd0) begin
            n_fail++; $display("FAIL stall_zero: got %h want 0000", stall_cnt);
        end
        in_valid = 1'b1; in_data = 32'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        n_tests++;
        if (stall_cnt !== 16'd100) begin
            n_fail++; $display("FAIL stall_count100: got %0d want 100", stall_cnt);
        end
        repeat (69900) @(posedge clk);
        #1;
        n_tests++;
        if (stall_cnt !== 16'hFFFF) begin
            n_fail++; $display("FAIL stall_saturate: got %h want ffff", stall_cnt);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_tests++;
        if (stall_cnt !== 16'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_flush: cnt=%h valid=%b want 0000/0", stall_cnt, out_valid);
        end
    endtask
`endif

    initial begin
        clk = 1'b0; rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_random();
`ifdef SKID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
